// File: rtl/peak_tracker.sv
// Running-extremum filter: reduces each GROUP-word block to its min or max and
// emits a one-cycle pulse whenever that group result strictly improves the running peak.
module peak_tracker #(
    parameter int DW        = 128,
    parameter int GROUP     = 8,
    parameter int SKIP_ZERO = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic          mode_max,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          peak_valid,
    output logic [DW-1:0] peak_data
);

    localparam int CW = $clog2(GROUP);
    localparam logic [CW-1:0] LAST = CW'(GROUP - 1);

    logic [CW-1:0] cnt;
    logic [DW-1:0] grp;
    logic          grp_hit;
    logic          grp_mode;
    logic          peak_mode;

    logic          accept;
    logic          qual;
    logic          first_word;
    logic          close_word;
    logic          word_wins;
    logic [DW-1:0] cand;
    logic          update;

    function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic is_max);
        return is_max ? (a > b) : (a < b);
    endfunction

    // Neutral group seed: loses to every qualifying word in the given mode.
    function automatic logic [DW-1:0] sentinel(input logic is_max);
        return is_max ? '0 : '1;
    endfunction

    always_comb begin
        accept     = en && in_valid && !clear;
        qual       = accept && !((SKIP_ZERO != 0) && (in_data == '0));
        first_word = (cnt == '0);
        close_word = (cnt == LAST);
        word_wins  = qual && better(in_data, grp, grp_mode);
        cand       = word_wins ? in_data : grp;
        update     = accept && close_word && (grp_hit || qual) &&
                     (!peak_valid || better(cand, peak_data, grp_mode));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            grp        <= '1;
            grp_hit    <= 1'b0;
            grp_mode   <= 1'b0;
            peak_mode  <= 1'b0;
            peak_valid <= 1'b0;
            peak_data  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (clear) begin
            cnt        <= '0;
            grp        <= sentinel(grp_mode);
            grp_hit    <= 1'b0;
            peak_valid <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= update;
            if (accept) begin
                cnt <= close_word ? '0 : cnt + 1'b1;
                if (first_word) begin
                    grp_mode <= mode_max;
                    grp      <= qual ? in_data : sentinel(mode_max);
                    grp_hit  <= qual;
                    // A peak found under the other mode is not comparable any more.
                    if (peak_valid && (mode_max != peak_mode))
                        peak_valid <= 1'b0;
                end else begin
                    if (word_wins)
                        grp <= in_data;
                    grp_hit <= grp_hit | qual;
                end
            end
            if (update) begin
                peak_data  <= cand;
                peak_valid <= 1'b1;
                peak_mode  <= grp_mode;
                out_data   <= cand;
            end
        end
    end

endmodule
